// File: rtl/gb_lcd_pkg.sv
// Shared timing constants and state encoding for the Game Boy style LCD link.
package gb_lcd_pkg;

  localparam int LCD_H_ACTIVE = 160;  // visible pixels per line
  localparam int LCD_V_ACTIVE = 144;  // visible lines per frame
  localparam int LCD_H_TOTAL  = 228;  // pixel slots per line
  localparam int LCD_V_TOTAL  = 154;  // lines per frame
  localparam int LCD_H_START  = 8;    // first visible slot
  localparam int LCD_HS_LEN   = 4;    // HSYNC slots

  localparam int LCD_HW = 8;   // slot counter width
  localparam int LCD_VW = 8;   // line counter width
  localparam int LCD_AW = 15;  // framebuffer address width

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PORCH,
    ACTIVE,
    BLANK
  } lcd_state_e;

endpackage

// File: rtl/gb_lcd_timing.sv
// Slot phase, slot (h) and line (v) counters; they only move while adv is high.
module gb_lcd_timing
  import gb_lcd_pkg::*;
#(
  parameter int H_TOTAL = LCD_H_TOTAL,
  parameter int V_TOTAL = LCD_V_TOTAL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  output logic [LCD_HW-1:0] h_d,
  output logic [LCD_VW-1:0] v_d,
  output logic              ph_d,
  output logic              frame_end
);

  localparam logic [LCD_HW-1:0] H_LAST = LCD_HW'(H_TOTAL - 1);
  localparam logic [LCD_VW-1:0] V_LAST = LCD_VW'(V_TOTAL - 1);

  logic [LCD_HW-1:0] h_q;
  logic [LCD_VW-1:0] v_q;
  logic              ph_q;

  // Next position: phase toggles each cycle, h steps after c1, v steps when h wraps.
  always_comb begin
    ph_d = ph_q;
    h_d  = h_q;
    v_d  = v_q;
    if (adv) begin
      ph_d = ~ph_q;
      if (ph_q) begin
        if (h_q == H_LAST) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
      end
    end
  end

  assign frame_end = ph_q && (h_q == H_LAST) && (v_q == V_LAST);

  // Position registers; reset parks at line 0, slot 0, phase c0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q  <= '0;
      v_q  <= '0;
      ph_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      ph_q <= ph_d;
    end
  end

endmodule

// File: rtl/gb_lcd_tx.sv
// LCD transmitter: frame state machine, framebuffer fetch and registered panel outputs.
// Every output flop is computed from the *next* state/position so that it lines
// up with the slot it describes.
module gb_lcd_tx
  import gb_lcd_pkg::*;
#(
  parameter int H_ACTIVE = LCD_H_ACTIVE,
  parameter int V_ACTIVE = LCD_V_ACTIVE,
  parameter int H_TOTAL  = LCD_H_TOTAL,
  parameter int V_TOTAL  = LCD_V_TOTAL,
  parameter int H_START  = LCD_H_START,
  parameter int HS_LEN   = LCD_HS_LEN
) (
  input  logic              CLK_3P3_MHZ,
  input  logic              RST,
  input  logic              EN,
  output logic              RD_EN,
  output logic [LCD_AW-1:0] RD_ADDR,
  input  logic [1:0]        RD_DATA,
  output logic              D0,
  output logic              D1,
  output logic              PX_CLK,
  output logic              HSYNC,
  output logic              VSYNC,
  output logic              FRAME_START,
  output logic              BUSY
);

  localparam logic [LCD_HW-1:0] HS_END  = LCD_HW'(HS_LEN);
  localparam logic [LCD_HW-1:0] HV_BEG  = LCD_HW'(H_START);
  localparam logic [LCD_HW-1:0] HV_END  = LCD_HW'(H_START + H_ACTIVE);
  localparam logic [LCD_HW:0]   HF_BEG  = (LCD_HW + 1)'(H_START);
  localparam logic [LCD_HW:0]   HF_END  = (LCD_HW + 1)'(H_START + H_ACTIVE);
  localparam logic [LCD_VW-1:0] V_VIS   = LCD_VW'(V_ACTIVE);
  localparam logic [LCD_AW-1:0] LINE_PX = LCD_AW'(H_ACTIVE);

  lcd_state_e        state_q, state_d;
  logic [LCD_HW-1:0] h_d;
  logic [LCD_VW-1:0] v_d;
  logic              ph_d;
  logic              frame_end;

  logic [LCD_HW:0]   h_fetch;
  logic [LCD_AW-1:0] pix_addr;

  logic              rd_en_q, rd_en_d;
  logic [LCD_AW-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]        pix_q, pix_d;
  logic              px_clk_q, px_clk_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              fs_q, fs_d;
  logic              busy_q, busy_d;

  gb_lcd_timing #(
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL)
  ) u_timing (
    .clk      (CLK_3P3_MHZ),
    .rst      (RST),
    .adv      (state_q != IDLE),
    .h_d      (h_d),
    .v_d      (v_d),
    .ph_d     (ph_d),
    .frame_end(frame_end)
  );

  function automatic lcd_state_e slot_state(input logic [LCD_HW-1:0] h,
                                            input logic [LCD_VW-1:0] v);
    if (h < HS_END) return SYNC;
    else if (h < HV_BEG) return PORCH;
    else if ((h < HV_END) && (v < V_VIS)) return ACTIVE;
    else return BLANK;
  endfunction

  // Next state: start from IDLE on EN; EN is only re-examined at the very end of a frame.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (EN) state_d = slot_state(h_d, v_d);
    end else if (frame_end && !EN) begin
      state_d = IDLE;
    end else begin
      state_d = slot_state(h_d, v_d);
    end
  end

  // The pixel for slot h is fetched in c0 of slot h-1 so it is ready for c0 of slot h.
  assign h_fetch  = {1'b0, h_d} + 1'b1;
  assign pix_addr = LCD_AW'(v_d) * LINE_PX + LCD_AW'(h_fetch - HF_BEG);

  // Output decode from the upcoming state and position.
  always_comb begin
    busy_d    = (state_d != IDLE);
    hsync_d   = (state_d == SYNC);
    vsync_d   = busy_d && (v_d == '0);
    fs_d      = busy_d && (v_d == '0) && (h_d == '0) && !ph_d;
    px_clk_d  = (state_d == ACTIVE) && !ph_d;
    rd_en_d   = busy_d && !ph_d && (v_d < V_VIS) &&
                (h_fetch >= HF_BEG) && (h_fetch < HF_END);
    rd_addr_d = rd_en_d ? pix_addr : rd_addr_q;
    pix_d     = 2'b00;
    if (state_d == ACTIVE) pix_d = ph_d ? pix_q : RD_DATA;
  end

  // State and output registers; reset clears everything at once.
  always_ff @(posedge CLK_3P3_MHZ or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      pix_q     <= 2'b00;
      px_clk_q  <= 1'b0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      fs_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      pix_q     <= pix_d;
      px_clk_q  <= px_clk_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      fs_q      <= fs_d;
      busy_q    <= busy_d;
    end
  end

  assign RD_EN       = rd_en_q;
  assign RD_ADDR     = rd_addr_q;
  assign D0          = pix_q[0];
  assign D1          = pix_q[1];
  assign PX_CLK      = px_clk_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign FRAME_START = fs_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_gb_lcd_tx.sv
// Directed bench for gb_lcd_tx with a shortened frame (3 visible + 2 blank lines)
// so several whole frames fit in a short run; line timing keeps its real values.
module tb_gb_lcd_tx;

  localparam int HA    = 160;
  localparam int VA    = 3;
  localparam int VT    = 5;
  localparam int LINE  = 456;
  localparam int FRAME = VT * LINE;
  localparam int NPIX  = HA * VA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        rd_en;
  logic [14:0] rd_addr;
  logic [1:0]  rd_data = 2'b00;
  logic        d0, d1, px_clk, hsync, vsync, frame_start, busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0]  mem [0:NPIX-1];
  logic [14:0] exp_last_addr;

  // per-frame statistics
  int m_hs, m_vs, m_px, m_rd, m_addr, m_d, m_busy, m_fs;
  int hs0, px0, first_px, hs_rise2, rd_cnt, vs_cnt;
  int line_act [0:VT-1];

  always #5 clk = ~clk;

  gb_lcd_tx #(.V_ACTIVE(VA), .V_TOTAL(VT)) dut (
    .CLK_3P3_MHZ(clk),
    .RST        (rst),
    .EN         (en),
    .RD_EN      (rd_en),
    .RD_ADDR    (rd_addr),
    .RD_DATA    (rd_data),
    .D0         (d0),
    .D1         (d1),
    .PX_CLK     (px_clk),
    .HSYNC      (hsync),
    .VSYNC      (vsync),
    .FRAME_START(frame_start),
    .BUSY       (busy)
  );

  // synchronous framebuffer: data one cycle after the read strobe
  always @(posedge clk) begin
    if (rd_en && (int'(rd_addr) < NPIX)) rd_data <= mem[rd_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Walk one frame from its FRAME_START cycle, comparing every cycle against a
  // timing model; optionally drop EN at cycle drop_t.
  task automatic run_frame(input string pfx, input int drop_t);
    int line, slot, ph;
    logic e_act, e_rd;
    logic [1:0] e_d;
    logic prev_hs;
    m_hs = 0; m_vs = 0; m_px = 0; m_rd = 0; m_addr = 0; m_d = 0; m_busy = 0; m_fs = 0;
    hs0 = 0; px0 = 0; first_px = -1; hs_rise2 = -1; rd_cnt = 0; vs_cnt = 0;
    for (int i = 0; i < VT; i++) line_act[i] = 0;
    prev_hs = 1'b0;
    for (int t = 0; t < FRAME; t++) begin
      line  = t / LINE;
      slot  = (t % LINE) / 2;
      ph    = t % 2;
      e_act = (slot >= 8) && (slot < 168) && (line < VA);
      e_rd  = (ph == 0) && (line < VA) && (slot >= 7) && (slot <= 166);
      if (e_rd) exp_last_addr = 15'(line * HA + slot - 7);
      e_d = 2'b00;
      if (e_act) e_d = mem[line * HA + slot - 8];
      if (hsync !== (slot < 4)) m_hs++;
      if (vsync !== (line == 0)) m_vs++;
      if (px_clk !== (e_act && (ph == 0))) m_px++;
      if (rd_en !== e_rd) m_rd++;
      if (rd_addr !== exp_last_addr) m_addr++;
      if ({d1, d0} !== e_d) m_d++;
      if (busy !== 1'b1) m_busy++;
      if (frame_start !== (t == 0)) m_fs++;
      if (t < LINE && hsync) hs0++;
      if (t < LINE && px_clk) px0++;
      if (px_clk && first_px < 0) first_px = t;
      if (hsync && !prev_hs && t > 0 && hs_rise2 < 0) hs_rise2 = t;
      prev_hs = hsync;
      if (rd_en) rd_cnt++;
      if (vsync) vs_cnt++;
      if (px_clk) line_act[line] = 1;
      if (t == drop_t) en = 1'b0;
      if (t < FRAME - 1) tick();
    end
    check({pfx, "_hsync_mism"}, m_hs, 0);
    check({pfx, "_vsync_mism"}, m_vs, 0);
    check({pfx, "_pxclk_mism"}, m_px, 0);
    check({pfx, "_rd_en_mism"}, m_rd, 0);
    check({pfx, "_rd_addr_mism"}, m_addr, 0);
    check({pfx, "_data_mism"}, m_d, 0);
    check({pfx, "_busy_mism"}, m_busy, 0);
    check({pfx, "_fs_mism"}, m_fs, 0);
  endtask

  initial begin
    int act_lines, fs_cnt;
    for (int i = 0; i < NPIX; i++) mem[i] = 2'($urandom_range(0, 3));
    exp_last_addr = '0;

    // reset state
    rst = 1'b1; en = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {rd_en, rd_addr, d1, d0, px_clk, hsync, vsync, frame_start, busy}, 0);
    rst = 1'b0;
    repeat (4) tick();
    check("idle_without_en", {busy, frame_start}, 0);

    // start: FRAME_START one cycle after EN
    en = 1'b1;
    tick();
    check("start_fs", frame_start, 1);
    check("start_vsync", vsync, 1);
    check("start_hsync", hsync, 1);

    // frame 1 with EN held
    run_frame("f1", -1);
    check("line0_hsync_cycles", hs0, 8);
    check("line0_px_pulses", px0, 160);
    check("first_px_offset", first_px, 16);
    check("line_period", hs_rise2, LINE);
    check("frame_rd_en_count", rd_cnt, NPIX);
    check("vsync_cycles", vs_cnt, LINE);
    act_lines = 0;
    for (int i = 0; i < VT; i++) act_lines += line_act[i];
    check("active_lines", act_lines, VA);
    check("silent_lines", VT - act_lines, VT - VA);
    tick();
    check("back_to_back_fs", frame_start, 1);

    // frame 2: EN dropped in line 1, frame must still complete
    run_frame("f2", LINE + 10);
    tick();
    check("en_drop_busy_low", busy, 0);
    fs_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (frame_start) fs_cnt++;
    end
    check("en_drop_no_restart", fs_cnt, 0);

    // reset asserted mid-active clears outputs immediately
    en = 1'b1;
    tick();
    check("f3_fs", frame_start, 1);
    repeat (LINE + 100) tick();
    check("f3_mid_active_pxclk", px_clk, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_outputs", {rd_en, rd_addr, d1, d0, px_clk, hsync, vsync, frame_start, busy}, 0);
    tick();
    rst = 1'b0; en = 1'b0;
    repeat (4) tick();
    check("rst_no_autostart", busy, 0);
    en = 1'b1;
    tick();
    check("restart_fs", frame_start, 1);
    check("restart_vsync", vsync, 1);
    check("restart_hsync", hsync, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
